seq_mixer: RTL and testbench

Time-multiplexed audio mixer, next generation of the combinational sound mixer. Snapshots N unsigned channel samples with per-channel 4-bit attenuation on each sample tick. Accumulates one channel per clock into a wide accumulator, applies a master attenuation and saturates. Presents a registered DAC word with a one-cycle valid strobe to the DAC serialiser. Replaces the N-adder chain with a single adder and adds enable masking, clip detection and overrun detection.

---
 rtl/mixer_pkg.sv | 13 +
 rtl/mixer_channel_scale.sv | 17 +
 rtl/seq_mixer.sv | 94 +++++++++
 tb/tb_seq_mixer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// mixer_pkg: shared FSM encoding and width helpers for the mixer family
package mixer_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
    function automatic int acc_width(input int dac_bits, input int channels);
        return dac_bits + clog2(channels);
    endfunction
endpackage

// File: rtl/mixer_channel_scale.sv
// mixer_channel_scale: left-justify a channel sample into the DAC width, attenuate and gate it
module mixer_channel_scale #(
    parameter int BIT_DEPTH     = 8,
    parameter int DAC_BIT_DEPTH = 12,
    parameter int AMP_WIDTH     = 4
) (
    input  logic [BIT_DEPTH-1:0]     sample,
    input  logic                     enable,
    input  logic [AMP_WIDTH-1:0]     amp,
    output logic [DAC_BIT_DEPTH-1:0] term
);
    logic [DAC_BIT_DEPTH-1:0] justified;
    always_comb begin
        justified = DAC_BIT_DEPTH'(sample) << (DAC_BIT_DEPTH - BIT_DEPTH);
        term      = enable ? justified >> amp : '0;
    end
endmodule

// File: rtl/seq_mixer.sv
// seq_mixer: time-multiplexed channel mixer with master attenuation, saturation and overrun detection
module seq_mixer
    import mixer_pkg::*;
#(
    parameter int BIT_DEPTH     = 8,
    parameter int DAC_BIT_DEPTH = 12,
    parameter int CHANNELS      = 10,
    parameter int AMP_WIDTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_tick,
    input  logic [CHANNELS*BIT_DEPTH-1:0]   samples,
    input  logic [CHANNELS*AMP_WIDTH-1:0]   amps,
    input  logic [CHANNELS-1:0]             ch_enable,
    input  logic [AMP_WIDTH-1:0]            master_amp,
    output logic [DAC_BIT_DEPTH-1:0]        data,
    output logic                            data_valid,
    output logic                            busy,
    output logic                            clip,
    output logic                            overrun
);
    localparam int ACC_W = acc_width(DAC_BIT_DEPTH, CHANNELS);
    localparam int IW    = clog2(CHANNELS) > 0 ? clog2(CHANNELS) : 1;
    localparam logic [ACC_W-1:0] DAC_MAX = ACC_W'({DAC_BIT_DEPTH{1'b1}});

    state_t                          state;
    logic [CHANNELS*BIT_DEPTH-1:0]   snap_samples;
    logic [CHANNELS*AMP_WIDTH-1:0]   snap_amps;
    logic [CHANNELS-1:0]             snap_enable;
    logic [AMP_WIDTH-1:0]            snap_master;
    logic [ACC_W-1:0]                acc;
    logic [ACC_W-1:0]                scaled;
    logic [IW-1:0]                   idx;
    logic [DAC_BIT_DEPTH-1:0]        term;
    logic                            sat;

    mixer_channel_scale #(
        .BIT_DEPTH    (BIT_DEPTH),
        .DAC_BIT_DEPTH(DAC_BIT_DEPTH),
        .AMP_WIDTH    (AMP_WIDTH)
    ) u_scale (
        .sample(snap_samples[idx*BIT_DEPTH +: BIT_DEPTH]),
        .enable(snap_enable[idx]),
        .amp   (snap_amps[idx*AMP_WIDTH +: AMP_WIDTH]),
        .term  (term)
    );

    always_comb begin
        scaled = acc >> snap_master;
        sat    = scaled > DAC_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (sample_tick) begin
                    snap_samples <= samples;
                    snap_amps    <= amps;
                    snap_enable  <= ch_enable;
                    snap_master  <= master_amp;
                    acc          <= '0;
                    idx          <= '0;
                    busy         <= 1'b1;
                    state        <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(term);
                    idx <= idx + 1'b1;
                    if (idx == IW'(CHANNELS - 1)) state <= OUTPUT;
                end
                OUTPUT: begin
                    data       <= sat ? '1 : scaled[DAC_BIT_DEPTH-1:0];
                    clip       <= sat;
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mixer.sv
// tb_seq_mixer: randomized and directed checks of seq_mixer against an arithmetic mixing model
module tb_seq_mixer;
    localparam int BIT = 8;
    localparam int DAC = 12;
    localparam int CH  = 10;
    localparam int AW  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_tick = 1'b0;
    logic [CH*BIT-1:0]   samples = '0;
    logic [CH*AW-1:0]    amps = '0;
    logic [CH-1:0]       ch_enable = '0;
    logic [AW-1:0]       master_amp = '0;
    logic [DAC-1:0]      data;
    logic                data_valid, busy, clip, overrun;
    int                  checks = 0;
    int                  errors = 0;

    seq_mixer #(.BIT_DEPTH(BIT), .DAC_BIT_DEPTH(DAC), .CHANNELS(CH), .AMP_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .samples(samples), .amps(amps),
        .ch_enable(ch_enable), .master_amp(master_amp), .data(data), .data_valid(data_valid),
        .busy(busy), .clip(clip), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic void model(output logic [DAC-1:0] d, output logic c);
        longint sum;
        sum = 0;
        for (int k = 0; k < CH; k++)
            if (ch_enable[k]) sum += (longint'(samples[k*BIT +: BIT]) * (2 ** (DAC - BIT))) >> amps[k*AW +: AW];
        sum = sum >> master_amp;
        c = sum > (2 ** DAC - 1);
        d = c ? {DAC{1'b1}} : DAC'(sum);
    endfunction

    task automatic clear_inputs();
        samples = '0; amps = '0; ch_enable = '0; master_amp = '0;
    endtask

    task automatic set_ch(input int k, input logic [BIT-1:0] s, input logic [AW-1:0] a);
        samples[k*BIT +: BIT] = s;
        amps[k*AW +: AW] = a;
        ch_enable[k] = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < CH; k++) begin
            samples[k*BIT +: BIT] = BIT'($urandom);
            amps[k*AW +: AW] = AW'($urandom_range(0, 13));
        end
        ch_enable = CH'($urandom);
        master_amp = AW'($urandom_range(0, 3));
    endtask

    // Starts a mix sampled at edge 0 and observes 16 cycles; events are scheduled by edge number.
    task automatic do_mix(input int tick_at, input int rst_at, input int chg_at,
                          output int vcyc, output int nvalid, output logic [15:0] busy_bits,
                          output logic [DAC-1:0] d, output logic c);
        vcyc = -1; nvalid = 0; busy_bits = '0; d = '0; c = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 16; n++) begin
            busy_bits[n] = busy;
            if (data_valid) begin
                nvalid++;
                if (vcyc < 0) begin vcyc = n; d = data; c = clip; end
            end
            sample_tick = (n == tick_at - 1);
            rst = (n == rst_at - 1);
            if (n == chg_at - 1) rand_inputs();
            @(negedge clk);
        end
        sample_tick = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        set_ch(0, 8'h80, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        sample_tick = 1'b0;
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
        checks++; if ({data_valid, busy, clip, overrun} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {data_valid, busy, clip, overrun}); end
        seen = 0;
        for (int n = 0; n < 14; n++) begin
            if (data_valid || busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_tick_ignored: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_single_channel();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d; logic c;
        clear_inputs(); set_ch(0, 8'h80, 4'd0);
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (vcyc !== 11) begin errors++; $display("FAIL single_latency: got %0d want 11", vcyc); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", nv); end
        checks++; if (d !== 12'h800 || c !== 1'b0) begin errors++; $display("FAIL single_data: got %h clip %b want 800 clip 0", d, c); end
        checks++; if (bb !== 16'h07FF) begin errors++; $display("FAIL single_busy: got %h want 07ff", bb); end
        checks++; if (data !== 12'h800 || data_valid !== 1'b0) begin errors++; $display("FAIL single_hold: got %h valid %b want 800 valid 0", data, data_valid); end
    endtask

    task automatic test_two_channels();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d; logic c;
        clear_inputs(); set_ch(0, 8'hFF, 4'd0); set_ch(1, 8'h01, 4'd3);
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (d !== 12'hFF2 || c !== 1'b0) begin errors++; $display("FAIL two_ch_m0: got %h clip %b want ff2 clip 0", d, c); end
        master_amp = 4'd1;
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (d !== 12'h7F9 || c !== 1'b0) begin errors++; $display("FAIL two_ch_m1: got %h clip %b want 7f9 clip 0", d, c); end
    endtask

    task automatic test_saturation();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d; logic c;
        clear_inputs(); set_ch(0, 8'h80, 4'd0); set_ch(1, 8'h80, 4'd0);
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (d !== 12'hFFF || c !== 1'b1) begin errors++; $display("FAIL sat_clip: got %h clip %b want fff clip 1", d, c); end
        checks++; if (clip !== 1'b1) begin errors++; $display("FAIL sat_clip_hold: got %b want 1", clip); end
        ch_enable[1] = 1'b0;
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (d !== 12'h800 || c !== 1'b0) begin errors++; $display("FAIL sat_recover: got %h clip %b want 800 clip 0", d, c); end
    endtask

    task automatic test_all_disabled();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d; logic c;
        rand_inputs(); ch_enable = '0;
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (nv !== 1 || vcyc !== 11) begin errors++; $display("FAIL disabled_valid: got %0d pulses at %0d want 1 at 11", nv, vcyc); end
        checks++; if (d !== '0 || c !== 1'b0) begin errors++; $display("FAIL disabled_data: got %h clip %b want 000 clip 0", d, c); end
    endtask

    task automatic test_random();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d, ed; logic c, ec;
        for (int i = 0; i < 12; i++) begin
            rand_inputs();
            if (i % 3 == 0) begin ch_enable = '1; master_amp = '0; end
            model(ed, ec);
            do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
            checks++; if (vcyc !== 11 || nv !== 1) begin errors++; $display("FAIL rand_timing[%0d]: got %0d pulses at %0d want 1 at 11", i, nv, vcyc); end
            checks++; if (d !== ed || c !== ec) begin errors++; $display("FAIL rand_data[%0d]: got %h clip %b want %h clip %b", i, d, c, ed, ec); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DAC-1:0] ed[$], gd[$]; logic ec[$], gc[$]; logic [DAC-1:0] d; logic c;
        for (int n = -1; n < 40; n++) begin
            if (n >= 0 && data_valid) begin gd.push_back(data); gc.push_back(clip); end
            if (n == -1 || n == 11 || n == 23) begin
                rand_inputs(); model(d, c); ed.push_back(d); ec.push_back(c); sample_tick = 1'b1;
            end else sample_tick = 1'b0;
            @(negedge clk);
        end
        checks++; if (gd.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", gd.size()); end
        for (int i = 0; i < 3 && i < gd.size(); i++) begin
            checks++; if (gd[i] !== ed[i] || gc[i] !== ec[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h clip %b want %h clip %b", i, gd[i], gc[i], ed[i], ec[i]); end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d, ed; logic c, ec;
        rand_inputs(); ch_enable[0] = 1'b1;
        model(ed, ec);
        do_mix(5, -1, 2, vcyc, nv, bb, d, c);
        checks++; if (d !== ed || c !== ec) begin errors++; $display("FAIL ovr_snapshot: got %h clip %b want %h clip %b", d, c, ed, ec); end
        checks++; if (nv !== 1 || vcyc !== 11) begin errors++; $display("FAIL ovr_valid: got %0d pulses at %0d want 1 at 11", nv, vcyc); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        rand_inputs(); model(ed, ec);
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (overrun !== 1'b1 || d !== ed) begin errors++; $display("FAIL ovr_sticky: got ovr %b data %h want ovr 1 data %h", overrun, d, ed); end
    endtask

    task automatic test_reset_mid_mix();
        int vcyc, nv; logic [15:0] bb; logic [DAC-1:0] d, ed; logic c, ec;
        clear_inputs(); set_ch(0, 8'h80, 4'd0); set_ch(1, 8'h80, 4'd0);
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        rand_inputs(); ch_enable = '1;
        do_mix(-1, 4, -1, vcyc, nv, bb, d, c);
        checks++; if (nv !== 0) begin errors++; $display("FAIL rstmix_valid: got %0d pulses want 0", nv); end
        checks++; if (data !== '0 || clip !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmix_state: got data %h clip %b busy %b ovr %b want all 0", data, clip, busy, overrun); end
        rand_inputs(); model(ed, ec);
        do_mix(-1, -1, -1, vcyc, nv, bb, d, c);
        checks++; if (vcyc !== 11 || d !== ed || c !== ec) begin errors++; $display("FAIL rstmix_after: got %h clip %b at %0d want %h clip %b at 11", d, c, vcyc, ed, ec); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_two_channels();
        test_saturation();
        test_all_disabled();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid_mix();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
